// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared widths, ALU opcodes and divider state encoding for the execute stage
package ex_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11,
        ALU_DIV  = 4'd12,
        ALU_DIVU = 4'd13,
        ALU_REM  = 4'd14,
        ALU_REMU = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_divider.sv
// rtl/ex_divider.sv - multi-cycle restoring radix-2 divider with start/busy/done handshake
module ex_divider
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    div_state_e      state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
    logic            neg_quo, neg_rem, dvsr_zero;
    logic [XLEN:0]   shifted, trial;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= DIV_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (start) state_next = DIV_BUSY;
            DIV_BUSY: if (cnt == CNT_LAST) state_next = DIV_DONE;
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // Quotient bits shift in from the bottom while the dividend drains out of the top into rem_q.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign trial   = shifted - {1'b0, dvsr_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            dvsr_zero <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= abs_val(dividend, is_signed);
            dvsr_q    <= abs_val(divisor, is_signed);
            neg_quo   <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_rem   <= is_signed && dividend[XLEN-1];
            dvsr_zero <= (divisor == '0);
        end else if (state == DIV_BUSY) begin
            cnt <= cnt + 1'b1;
            if (!trial[XLEN]) begin
                rem_q <= trial[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Divide-by-zero must report all ones regardless of the dividend's sign.
    assign quotient  = dvsr_zero ? '1 : (neg_quo ? (~quo_q + 1'b1) : quo_q);
    assign remainder = neg_rem ? (~rem_q + 1'b1) : rem_q;
    assign busy      = (state == DIV_BUSY);
    assign done      = (state == DIV_DONE);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, single-cycle ALU, divider control, EX/MEM register
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter bit DIV_EN     = 1'b1,
    parameter int DIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  e_valid_i,
    input  logic                  e_write_reg_i,
    input  logic                  e_mem_to_reg_i,
    input  logic                  e_write_mem_i,
    input  logic [3:0]            alu_op_i,
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [REG_ADDR_W-1:0] rt_addr_i,
    input  logic [XLEN-1:0]       rs_val_i,
    input  logic [XLEN-1:0]       rt_val_i,
    input  logic [XLEN-1:0]       imm_i,
    input  logic                  use_imm_i,
    input  logic [REG_ADDR_W-1:0] e_des_r_i,
    input  logic                  wb_write_reg_i,
    input  logic [REG_ADDR_W-1:0] wb_des_r_i,
    input  logic [XLEN-1:0]       wb_data_i,
    output logic                  stall_o,
    output logic                  m_write_reg_o,
    output logic                  m_mem_to_reg_o,
    output logic                  m_write_mem_o,
    output logic [XLEN-1:0]       alu_result_o,
    output logic [XLEN-1:0]       write_mem_val_o,
    output logic [REG_ADDR_W-1:0] m_des_r_o
);

    alu_op_e         op;
    logic [XLEN-1:0] fwd_rs, fwd_rt, op_a, op_b, alu_res;
    logic [XLEN-1:0] div_quo, div_rem;
    logic            div_stall;
    logic            mem_fwd_ok;

    assign op = alu_op_e'(alu_op_i);

    // A load's MEM-stage value is an address, not the register result, so it never forwards.
    assign mem_fwd_ok = m_write_reg_o && !m_mem_to_reg_o;

    always_comb begin
        fwd_rs = rs_val_i;
        if (mem_fwd_ok && m_des_r_o == rs_addr_i && rs_addr_i != '0)
            fwd_rs = alu_result_o;
        else if (wb_write_reg_i && wb_des_r_i == rs_addr_i && rs_addr_i != '0)
            fwd_rs = wb_data_i;
    end

    always_comb begin
        fwd_rt = rt_val_i;
        if (mem_fwd_ok && m_des_r_o == rt_addr_i && rt_addr_i != '0)
            fwd_rt = alu_result_o;
        else if (wb_write_reg_i && wb_des_r_i == rt_addr_i && rt_addr_i != '0)
            fwd_rt = wb_data_i;
    end

    assign op_a = fwd_rs;
    assign op_b = use_imm_i ? imm_i : fwd_rt;

    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_SLL:  alu_res = op_a << op_b[4:0];
            ALU_SRL:  alu_res = op_a >> op_b[4:0];
            ALU_SRA:  alu_res = $signed(op_a) >>> op_b[4:0];
            ALU_LUI:  alu_res = {op_b[15:0], 16'h0000};
            ALU_DIV, ALU_DIVU: alu_res = div_quo;
            ALU_REM, ALU_REMU: alu_res = div_rem;
            default:  alu_res = '0;
        endcase
    end

    generate
        if (DIV_EN) begin : g_div
            logic div_busy, div_done, div_start;

            assign div_start = rst_n && e_valid_i && is_div_op(alu_op_i) && !div_busy && !div_done;
            assign div_stall = div_start || div_busy;

            ex_divider #(.DIV_CYCLES(DIV_CYCLES)) u_divider (
                .clk       (clk),
                .rst_n     (rst_n),
                .start     (div_start),
                .is_signed (op == ALU_DIV || op == ALU_REM),
                .dividend  (op_a),
                .divisor   (op_b),
                .busy      (div_busy),
                .done      (div_done),
                .quotient  (div_quo),
                .remainder (div_rem)
            );
        end else begin : g_no_div
            assign div_stall = 1'b0;
            assign div_quo   = '0;
            assign div_rem   = '0;
        end
    endgenerate

    assign stall_o = div_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_write_reg_o   <= 1'b0;
            m_mem_to_reg_o  <= 1'b0;
            m_write_mem_o   <= 1'b0;
            alu_result_o    <= '0;
            write_mem_val_o <= '0;
            m_des_r_o       <= '0;
        end else begin
            if (e_valid_i && !stall_o) begin
                m_write_reg_o  <= e_write_reg_i;
                m_mem_to_reg_o <= e_mem_to_reg_i;
                m_write_mem_o  <= e_write_mem_i;
            end else begin
                m_write_reg_o  <= 1'b0;
                m_mem_to_reg_o <= 1'b0;
                m_write_mem_o  <= 1'b0;
            end
            alu_result_o    <= alu_res;
            write_mem_val_o <= fwd_rt;
            m_des_r_o       <= e_des_r_i;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage with directed vectors
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        e_valid_i, e_write_reg_i, e_mem_to_reg_i, e_write_mem_i;
    logic [3:0]  alu_op_i;
    logic [4:0]  rs_addr_i, rt_addr_i, e_des_r_i, wb_des_r_i;
    logic [31:0] rs_val_i, rt_val_i, imm_i, wb_data_i;
    logic        use_imm_i, wb_write_reg_i;
    logic        stall_o, m_write_reg_o, m_mem_to_reg_o, m_write_mem_o;
    logic [31:0] alu_result_o, write_mem_val_o;
    logic [4:0]  m_des_r_o;

    typedef struct {
        int          tag;
        logic [4:0]  des;
        logic [31:0] res;
        logic        m2r;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tag_cnt = 0;

    ex_stage #(.DIV_EN(1'b1), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .e_valid_i(e_valid_i), .e_write_reg_i(e_write_reg_i),
        .e_mem_to_reg_i(e_mem_to_reg_i), .e_write_mem_i(e_write_mem_i),
        .alu_op_i(alu_op_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
        .rs_val_i(rs_val_i), .rt_val_i(rt_val_i), .imm_i(imm_i), .use_imm_i(use_imm_i),
        .e_des_r_i(e_des_r_i), .wb_write_reg_i(wb_write_reg_i), .wb_des_r_i(wb_des_r_i),
        .wb_data_i(wb_data_i), .stall_o(stall_o), .m_write_reg_o(m_write_reg_o),
        .m_mem_to_reg_o(m_mem_to_reg_o), .m_write_mem_o(m_write_mem_o),
        .alu_result_o(alu_result_o), .write_mem_val_o(write_mem_val_o), .m_des_r_o(m_des_r_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && m_write_reg_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got des=%0d res=%h, required no write", m_des_r_o, alu_result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (m_des_r_o !== e.des || alu_result_o !== e.res || m_mem_to_reg_o !== e.m2r) begin
                    errors++;
                    $display("FAIL write_%0d: got des=%0d res=%h m2r=%b, required des=%0d res=%h m2r=%b",
                             e.tag, m_des_r_o, alu_result_o, m_mem_to_reg_o, e.des, e.res, e.m2r);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [3:0] op,
                         input logic [4:0] rsa, input logic [31:0] rsv,
                         input logic [4:0] rta, input logic [31:0] rtv,
                         input logic [31:0] imm, input logic ui,
                         input logic [4:0] des, input logic m2r);
        e_valid_i      = valid;
        e_write_reg_i  = 1'b1;
        e_mem_to_reg_i = m2r;
        e_write_mem_i  = 1'b0;
        alu_op_i       = op;
        rs_addr_i      = rsa;
        rs_val_i       = rsv;
        rt_addr_i      = rta;
        rt_val_i       = rtv;
        imm_i          = imm;
        use_imm_i      = ui;
        e_des_r_i      = des;
    endtask

    task automatic push(input logic [4:0] des, input logic [31:0] res, input logic m2r);
        exp_t e;
        tag_cnt++;
        e.tag = tag_cnt; e.des = des; e.res = res; e.m2r = m2r;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rsa, input logic [31:0] rsv,
                         input logic [4:0] rta, input logic [31:0] rtv, input logic [31:0] imm,
                         input logic ui, input logic [4:0] des, input logic m2r, input logic [31:0] exp);
        drive(1'b1, op, rsa, rsv, rta, rtv, imm, ui, des, m2r);
        #1;
        check("single_cycle_stall", {31'b0, stall_o}, 32'd0);
        push(des, exp, m2r);
        @(posedge clk); #1;
    endtask

    task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] des, input logic [31:0] exp);
        int n;
        drive(1'b1, op, 5'd20, a, 5'd21, b, 32'd0, 1'b0, des, 1'b0);
        #1;
        n = 0;
        while (stall_o && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        check("div_stall_cycles", 32'(n), 32'd33);
        push(des, exp, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        wb_write_reg_i = 1'b0; wb_des_r_i = 5'd0; wb_data_i = 32'd0;
        drive(1'b1, ALU_ADD, 5'd5, 32'd7, 5'd0, 32'd0, 32'd3, 1'b1, 5'd9, 1'b0);
        @(posedge clk); #1;
        check("reset_write_reg", {31'b0, m_write_reg_o}, 32'd0);
        check("reset_result", alu_result_o, 32'd0);
        check("reset_des", {27'b0, m_des_r_o}, 32'd0);
        check("reset_store_val", write_mem_val_o, 32'd0);
        rst_n = 1'b1;

        issue(ALU_ADD, 5'd5, 32'd7, 5'd0, 32'd0, 32'd3, 1'b1, 5'd9, 1'b0, 32'd10);
        issue(ALU_SLT,  5'd20, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd1,  1'b1, 5'd10, 1'b0, 32'd1);
        issue(ALU_SLTU, 5'd20, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd1,  1'b1, 5'd10, 1'b0, 32'd0);
        issue(ALU_SRA,  5'd20, 32'h8000_0000, 5'd0, 32'd0, 32'd4,  1'b1, 5'd10, 1'b0, 32'hF800_0000);
        issue(ALU_SRL,  5'd20, 32'h8000_0000, 5'd0, 32'd0, 32'd4,  1'b1, 5'd10, 1'b0, 32'h0800_0000);
        issue(ALU_SLL,  5'd20, 32'd1,         5'd0, 32'd0, 32'd31, 1'b1, 5'd10, 1'b0, 32'h8000_0000);
        issue(ALU_LUI,  5'd0,  32'd0,         5'd0, 32'd0, 32'h1234, 1'b1, 5'd10, 1'b0, 32'h1234_0000);
        issue(ALU_NOR,  5'd20, 32'h0F0F_0F0F, 5'd21, 32'hF0F0_0000, 32'd0, 1'b0, 5'd10, 1'b0, 32'h0000_F0F0);

        // Forwarding priority: MEM beats WB, loads in MEM defer to WB, r0 never forwards.
        issue(ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 32'h11, 1'b1, 5'd4, 1'b0, 32'h11);
        wb_write_reg_i = 1'b1; wb_des_r_i = 5'd4; wb_data_i = 32'h22;
        issue(ALU_SUB, 5'd4, 32'h99, 5'd0, 32'd0, 32'd0, 1'b0, 5'd7, 1'b0, 32'h11);
        issue(ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 32'h11, 1'b1, 5'd4, 1'b1, 32'h11);
        issue(ALU_SUB, 5'd4, 32'h99, 5'd0, 32'd0, 32'd0, 1'b0, 5'd7, 1'b0, 32'h22);
        wb_des_r_i = 5'd0;
        issue(ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 32'h33, 1'b1, 5'd0, 1'b0, 32'h33);
        issue(ALU_SUB, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd7, 1'b0, 32'd0);
        wb_write_reg_i = 1'b0;
        issue(ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 32'h44, 1'b1, 5'd5, 1'b0, 32'h44);
        issue(ALU_SUB, 5'd20, 32'h100, 5'd5, 32'd0, 32'd0, 1'b0, 5'd7, 1'b0, 32'hBC);
        check("store_fwd_rt", write_mem_val_o, 32'h44);

        run_div(ALU_DIV,  32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFD);
        run_div(ALU_REM,  32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFF);
        run_div(ALU_DIVU, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
        run_div(ALU_REMU, 32'd5, 32'd0, 5'd14, 32'd5);
        run_div(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
        run_div(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0);
        run_div(ALU_REM,  32'd7, 32'hFFFF_FFFE, 5'd17, 32'd1);
        run_div(ALU_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd18, 32'h0FFF_FFFF);
        drive(1'b0, ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end

        // Reset during a division: partial result must never reach mem.
        drive(1'b1, ALU_DIV, 5'd20, 32'd100, 5'd21, 32'd7, 32'd0, 1'b0, 5'd19, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("mid_div_stall", {31'b0, stall_o}, 32'd1);
        rst_n = 1'b0;
        e_valid_i = 1'b0;
        @(posedge clk); #1;
        check("mid_div_reset_stall", {31'b0, stall_o}, 32'd0);
        check("mid_div_reset_write", {31'b0, m_write_reg_o}, 32'd0);
        check("mid_div_reset_result", alu_result_o, 32'd0);
        rst_n = 1'b1;
        issue(ALU_ADD, 5'd20, 32'd40, 5'd0, 32'd0, 32'd2, 1'b1, 5'd3, 1'b0, 32'd42);
        drive(1'b0, ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        repeat (40) begin @(posedge clk); #1; end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits between the ID/EX register and the `mem` stage, and drives `mem`'s inputs directly.
- Forwards operands from the MEM and WB stages, then computes single-cycle ALU results.
- Runs a multi-cycle radix-2 divider that stalls the front end.
- Registers the control and data fields that `mem` consumes.

Parameters:
- DIV_EN, 1. 1 instantiates the divider; 0 turns DIV/DIVU/REM/REMU into single-cycle ops that return 0.
- DIV_CYCLES, 32. Number of iteration cycles of the divider. Equals the data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- e_valid_i  in  1  ID/EX holds a real instruction
- e_write_reg_i  in  1  instruction writes a register
- e_mem_to_reg_i  in  1  instruction is a load
- e_write_mem_i  in  1  instruction is a store
- alu_op_i  in  `AluOpBus (4)  operation select
- rs_addr_i, rt_addr_i  in  `RegAddrBus  source register numbers used for forwarding
- rs_val_i, rt_val_i  in  `RegDataBus  register-file read values
- imm_i  in  `RegDataBus  sign/zero-extended immediate
- use_imm_i  in  1  1 selects imm_i as operand B
- e_des_r_i  in  `RegAddrBus  destination register
- wb_write_reg_i  in  1  WB-stage write enable
- wb_des_r_i  in  `RegAddrBus  WB-stage destination register
- wb_data_i  in  `RegDataBus  WB-stage write data
- stall_o  out  1  combinational; ID/EX must hold its contents while high
- m_write_reg_o, m_mem_to_reg_o, m_write_mem_o  out  1 each  to `mem`
- alu_result_o  out  `RegDataBus  to `mem`
- write_mem_val_o  out  `RegDataBus  store data (forwarded rt)
- m_des_r_o  out  `RegAddrBus  to `mem`

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - This applies mid-division too: the partial result is discarded and no write is emitted.
- Forwarding, per source register (rs and rt independently):
  - Priority 1, MEM: if m_write_reg_o && !m_mem_to_reg_o && m_des_r_o==addr && addr!=0, use alu_result_o.
  - Priority 2, WB: else if wb_write_reg_i && wb_des_r_i==addr && addr!=0, use wb_data_i.
  - Otherwise use the register-file value.
  - Load-use hazards are resolved in ID and are not handled here.
- Operands:
  - A = forwarded rs.
  - B = use_imm_i ? imm_i : forwarded rt.
  - write_mem_val_o always takes forwarded rt.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI.
  - Results are 32-bit modulo; no overflow trap.
  - Shift amount is B[4:0]. LUI result is {B[15:0],16'h0}.
  - Latency is 1 cycle: outputs are registered at the edge that ends the issue cycle.
- Bubble:
  - If e_valid_i is 0, the edge registers m_write_reg_o = m_mem_to_reg_o = m_write_mem_o = 0.
  - Data outputs in a bubble are don't-care.
- Divider FSM (IDLE, BUSY, DONE):
  - IDLE with valid div op at cycle T:
    - Latch |A|, |B| and the sign flags; zero the counter.
    - Assert stall_o and register a bubble to `mem`.
  - BUSY, T+1..T+DIV_CYCLES:
    - One restoring-shift step per cycle.
    - stall_o stays 1 and a bubble is registered each cycle.
  - DONE, T+DIV_CYCLES+1:
    - stall_o drops to 0.
    - The edge registers the sign-corrected quotient or remainder plus the instruction's control fields; the FSM returns to IDLE.
  - Total occupancy is DIV_CYCLES+2 cycles.
- Divider special cases:
  - Divide by zero: quotient = 32'hFFFF_FFFF; remainder = dividend.
  - Signed -2^31 / -1: quotient = 32'h8000_0000; remainder = 0.
  - Remainder takes the sign of the dividend.
- Operand timing:
  - Operands are latched at start, so forwarding sources vanishing during BUSY are harmless.
  - ID/EX fields are held by the stall, so the destination and control fields are read in DONE.
- Back-to-back divs: the second div starts in the cycle after DONE (IDLE path); there is no overlap.

Decomposition:
- macros.v gains:
  - `AluOpBus and the opcodes `ALU_ADD .. `ALU_LUI, `ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU.
  - `DivCntBus.
- One sub-module, ex_divider. It owns the FSM, counter and shift registers, with a start/busy/done handshake, and is instantiated when DIV_EN=1.
- Forwarding and the ALU stay in ex_stage.

Test Plan:
- Reset: rst_n=0 during a valid ADD -> all outputs 0 on the next edge.
- Single-cycle ADD: ADD rs=5 (val 7), imm 3, des 9, write_reg=1 -> next edge: alu_result_o=10, m_des_r_o=9, m_write_reg_o=1, stall_o never high.
- Forwarding priority: MEM holds r4=0x11 and WB writes r4=0x22; SUB rs=r4, rt=r0 -> result 0x11. Repeat with MEM a load -> result 0x22. Repeat with rs=r0 -> result 0.
- Signed division: DIV -7/2 at T -> stall_o high T..T+32, bubbles during that window; after edge T+33: alu_result_o=32'hFFFF_FFFD. REM of the same operands -> 32'hFFFF_FFFF.
- Division corner cases: DIVU 5/0 -> 32'hFFFF_FFFF. REMU 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000. REM of the same -> 0.
- Reset mid-divide: rst_n=0 at T+10 of a DIV -> FSM returns to IDLE, stall_o=0, and no write appears at `mem`. A following ADD completes in 1 cycle.
